// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage ARM pipeline: forwarding selects, load-use and
// PC-write stalls, flushes, a registered PC-write tracker and saturating event counters.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             MemtoRegE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcD,
  input  logic             BranchE,
  input  logic             CondExE,
  input  logic             cnt_clr,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             PCSrcW,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic ldr_stall;
  logic branch_taken_e;
  logic pc_wr_pending;
  logic pc_e_q, pc_e_d;
  logic pc_m_q, pc_m_d;
  logic pc_w_q, pc_w_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // R15 reads the PC, never a forwarded result; the M stage wins over W.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                         input logic [3:0] wa_m,
                                         input logic       we_m,
                                         input logic [3:0] wa_w,
                                         input logic       we_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != 4'd15) begin
      if (we_m && (ra == wa_m)) begin
        sel = 2'b10;
      end else if (we_w && (ra == wa_w)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
    ForwardBE = fwd_sel(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);
  end

  always_comb begin
    ldr_stall      = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
    branch_taken_e = BranchE && CondExE;
    pc_wr_pending  = PCSrcD || pc_e_q || pc_m_q;

    StallF = ldr_stall || pc_wr_pending;
    StallD = ldr_stall;
    FlushD = pc_wr_pending || pc_w_q || branch_taken_e;
    FlushE = ldr_stall || branch_taken_e;
    PCSrcW = pc_w_q;
  end

  // A PC write flushed out of E is re-presented by D, so the tracker drops it here.
  always_comb begin
    pc_e_d = FlushE ? 1'b0 : PCSrcD;
    pc_m_d = pc_e_q && CondExE;
    pc_w_d = pc_m_q;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (StallF && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if ((FlushD || FlushE) && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_e_q      <= 1'b0;
      pc_m_q      <= 1'b0;
      pc_w_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_e_q      <= pc_e_d;
      pc_m_q      <= pc_m_d;
      pc_w_q      <= pc_w_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: the driver pushes hand-computed output
// vectors into a queue, and a negedge monitor pops and compares them.
module tb_hazard_ctrl;

  localparam int CW = 16;
  localparam int W  = 4 + 4 + 1 + 2 * CW;

  logic          clk;
  logic          reset;
  logic [3:0]    RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic          MemtoRegE, RegWriteM, RegWriteW, PCSrcD, BranchE, CondExE, cnt_clr;
  logic          StallF, StallD, FlushD, FlushE, PCSrcW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [CW-1:0] StallCnt, FlushCnt;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  string        name_q[$];
  int           n_checks;
  int           n_pass;

  localparam logic [W-1:0] M_ALL  = '1;
  localparam logic [W-1:0] M_CTRL = {{(W - 2 * CW){1'b1}}, {(2 * CW){1'b0}}};

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcD(PCSrcD), .BranchE(BranchE), .CondExE(CondExE), .cnt_clr(cnt_clr),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .PCSrcW(PCSrcW),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ev(input logic sf, input logic sd, input logic fd,
                                      input logic fe, input logic [1:0] fa,
                                      input logic [1:0] fb, input logic pw,
                                      input int sc, input int fc);
    logic [CW-1:0] s, f;
    s = sc[CW-1:0];
    f = fc[CW-1:0];
    return {sf, sd, fd, fe, fa, fb, pw, s, f};
  endfunction

  // Driver tasks
  task automatic idle();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
    MemtoRegE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    PCSrcD = 1'b0; BranchE = 1'b0; CondExE = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk(input string nm, input logic [W-1:0] e, input logic [W-1:0] m);
    exp_q.push_back(e);
    msk_q.push_back(m);
    name_q.push_back(nm);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [W-1:0] got, e, m;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        m  = msk_q.pop_front();
        nm = name_q.pop_front();
        got = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, PCSrcW, StallCnt, FlushCnt};
        n_checks++;
        if ((got & m) === (e & m)) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got sf/sd/fd/fe=%b%b%b%b fa=%b fb=%b pcw=%b sc=%0d fc=%0d, expected %h (mask %h) got %h",
                   nm, got[W-1], got[W-2], got[W-3], got[W-4], got[W-5 -: 2], got[W-7 -: 2],
                   got[2*CW], got[2*CW-1 -: CW], got[CW-1:0], e & m, m, got & m);
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_state", ev(0,0,0,0,2'b00,2'b00,0,0,0), M_ALL);

    // Forwarding
    cyc(); RA1E = 4'd3; RA2E = 4'd4; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
    chk("fwd_m_priority", ev(0,0,0,0,2'b10,2'b00,0,0,0), M_ALL);
    cyc(); RA1E = 4'd3; RA2E = 4'd4; WA3M = 4'd3; RegWriteM = 1'b0; WA3W = 4'd3; RegWriteW = 1'b1;
    chk("fwd_w_only", ev(0,0,0,0,2'b01,2'b00,0,0,0), M_ALL);
    cyc(); RA1E = 4'd15; RA2E = 4'd7; WA3M = 4'd15; RegWriteM = 1'b1; WA3W = 4'd7; RegWriteW = 1'b1;
    chk("fwd_r15_none", ev(0,0,0,0,2'b00,2'b01,0,0,0), M_ALL);
    cyc(); RA1E = 4'd0; RA2E = 4'd9; WA3M = 4'd9; RegWriteM = 1'b1; WA3W = 4'd0; RegWriteW = 1'b1;
    chk("fwd_b_from_m", ev(0,0,0,0,2'b01,2'b10,0,0,0), M_ALL);

    // Load-use
    cyc(); MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
    chk("ldr_stall_ra2", ev(1,1,0,1,2'b00,2'b00,0,0,0), M_ALL);
    cyc();
    chk("ldr_release", ev(0,0,0,0,2'b00,2'b00,0,1,1), M_ALL);
    cyc(); MemtoRegE = 1'b1; WA3E = 4'd2; RA1D = 4'd2; RA2D = 4'd9;
    chk("ldr_stall_ra1", ev(1,1,0,1,2'b00,2'b00,0,1,1), M_ALL);
    cyc(); MemtoRegE = 1'b1; WA3E = 4'd5; RA1D = 4'd4; RA2D = 4'd6;
    chk("ldr_no_match", ev(0,0,0,0,2'b00,2'b00,0,2,2), M_ALL);

    // Taken PC write
    cyc(); cnt_clr = 1'b1;
    chk("clr_cycle", ev(0,0,0,0,2'b00,2'b00,0,2,2), M_ALL);
    cyc(); PCSrcD = 1'b1; CondExE = 1'b1;
    chk("pcw_d", ev(1,0,1,0,2'b00,2'b00,0,0,0), M_ALL);
    cyc(); CondExE = 1'b1;
    chk("pcw_e", ev(1,0,1,0,2'b00,2'b00,0,1,1), M_ALL);
    cyc(); CondExE = 1'b1;
    chk("pcw_m", ev(1,0,1,0,2'b00,2'b00,0,2,2), M_ALL);
    cyc(); CondExE = 1'b1;
    chk("pcw_w", ev(0,0,1,0,2'b00,2'b00,1,3,3), M_ALL);
    cyc();
    chk("pcw_done", ev(0,0,0,0,2'b00,2'b00,0,3,4), M_ALL);

    // Conditional fail drops the PC write in E
    cyc(); PCSrcD = 1'b1;
    chk("pcf_d", ev(1,0,1,0,2'b00,2'b00,0,3,4), M_ALL);
    cyc();
    chk("pcf_e", ev(1,0,1,0,2'b00,2'b00,0,4,5), M_ALL);
    cyc();
    chk("pcf_dropped", ev(0,0,0,0,2'b00,2'b00,0,5,6), M_ALL);
    cyc();
    chk("pcf_no_pcsrcw", ev(0,0,0,0,2'b00,2'b00,0,5,6), M_ALL);

    // Branch in E
    cyc(); BranchE = 1'b1; CondExE = 1'b1;
    chk("br_taken", ev(0,0,1,1,2'b00,2'b00,0,5,6), M_ALL);
    cyc(); BranchE = 1'b1;
    chk("br_not_taken", ev(0,0,0,0,2'b00,2'b00,0,5,7), M_ALL);
    cyc();
    chk("br_idle", ev(0,0,0,0,2'b00,2'b00,0,5,7), M_ALL);

    // Load-use colliding with a PC write: write held in D
    cyc(); MemtoRegE = 1'b1; WA3E = 4'd5; RA1D = 4'd5; PCSrcD = 1'b1; CondExE = 1'b1;
    chk("ldr_pcw_both", ev(1,1,1,1,2'b00,2'b00,0,5,7), M_ALL);
    cyc(); PCSrcD = 1'b1; CondExE = 1'b1;
    chk("ldr_pcw_repres", ev(1,0,1,0,2'b00,2'b00,0,6,8), M_ALL);
    cyc(); CondExE = 1'b1;
    chk("ldr_pcw_e", ev(1,0,1,0,2'b00,2'b00,0,7,9), M_ALL);
    cyc(); CondExE = 1'b1;
    chk("ldr_pcw_m", ev(1,0,1,0,2'b00,2'b00,0,8,10), M_ALL);
    cyc();
    chk("ldr_pcw_w", ev(0,0,1,0,2'b00,2'b00,1,9,11), M_ALL);
    cyc();
    chk("ldr_pcw_done", ev(0,0,0,0,2'b00,2'b00,0,9,12), M_ALL);

    // Clear concurrent with an event
    cyc(); cnt_clr = 1'b1; BranchE = 1'b1; CondExE = 1'b1; MemtoRegE = 1'b1; WA3E = 4'd1; RA1D = 4'd1;
    chk("clr_with_event", ev(1,1,1,1,2'b00,2'b00,0,9,12), M_ALL);
    cyc();
    chk("clr_result", ev(0,0,0,0,2'b00,2'b00,0,0,0), M_ALL);

    // Saturation: stall and flush held for 70000 cycles
    for (int i = 0; i < 70000; i++) begin
      cyc(); MemtoRegE = 1'b1; WA3E = 4'd5; RA1D = 4'd5;
    end
    cyc(); MemtoRegE = 1'b1; WA3E = 4'd5; RA1D = 4'd5;
    chk("sat_reached", ev(1,1,0,1,2'b00,2'b00,0,65535,65535), M_ALL);
    cyc(); MemtoRegE = 1'b1; WA3E = 4'd5; RA1D = 4'd5;
    chk("sat_held", ev(1,1,0,1,2'b00,2'b00,0,65535,65535), M_ALL);

    // Reset while pcM is active
    cyc(); PCSrcD = 1'b1; CondExE = 1'b1;
    chk("rst_pcw_d", ev(1,0,1,0,2'b00,2'b00,0,0,0), M_CTRL);
    cyc(); CondExE = 1'b1;
    chk("rst_pcw_e", ev(1,0,1,0,2'b00,2'b00,0,0,0), M_CTRL);
    cyc(); CondExE = 1'b1; reset = 1'b1;
    chk("rst_pcw_m", ev(1,0,1,0,2'b00,2'b00,0,65535,65535), M_ALL);
    cyc(); reset = 1'b0;
    chk("rst_cleared", ev(0,0,0,0,2'b00,2'b00,0,0,0), M_ALL);
    cyc();
    chk("rst_after", ev(0,0,0,0,2'b00,2'b00,0,0,0), M_ALL);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
